muldiv_seq: RTL and testbench
=============================

// Module: muldiv_seq
// PURPOSE
//  Iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers. It computes by
//  borrowing the shared 32-bit datapath ALU (adder path) one add/subtract per cycle.
//  The ALU operand muxes are steered by alu_sel. While busy=1 the core stalls MFHI/MFLO
//  and any ALU-using instruction.
// PARAMETERS
//  WIDTH   32   operand/HI/LO width; iteration count = WIDTH
// PORTS
//  clk         in   1      rising-edge clock
//  reset       in   1      synchronous, active-high; clears all state
//  start       in   1      launch op; sampled only in IDLE
//  op          in   2      00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//  srca        in   WIDTH  rs: multiplicand / dividend
//  srcb        in   WIDTH  rt: multiplier / divisor
//  hi_we       in   1      MTHI write strobe
//  lo_we       in   1      MTLO write strobe
//  wd          in   WIDTH  MTHI/MTLO data
//  busy        out  1      high in every non-IDLE state
//  done        out  1      one-cycle pulse; HI/LO valid
//  hi, lo      out  WIDTH  HI/LO registers (direct register outputs)
//  alu_sel     out  1      1 = ALU operands taken from alu_a/alu_b/alucont
//  alu_a       out  WIDTH  ALU operand a
//  alu_b       out  WIDTH  ALU operand b
//  alucont     out  4      4'b0010 add, 4'b0110 subtract (ALU encoding)
//  alu_result  in   WIDTH  shared ALU result, combinational, same cycle
// BEHAVIOUR
//  Reset (sync): state=IDLE; busy=0, done=0, alu_sel=0; hi=lo=0; alu_a=alu_b=0; alucont=4'b0010.
//  FSM: IDLE -> PREP -> ITER (x WIDTH) -> FIXUP -> DONE -> IDLE.
//  Timing: start=1 in IDLE during cycle 0. PREP in cycle 1. ITER in cycles 2..33.
//   FIXUP in cycle 34; hi/lo load at the end of cycle 34. DONE in cycle 35 (done=1).
//   The block is back in IDLE in cycle 36. busy=1 in cycles 1..35.
//  Back-to-back: start is accepted again in cycle 36 at the earliest.
//   start in any non-IDLE state is ignored; no queueing.
//  Operand capture: op, srca and srcb are latched in IDLE when start=1.
//   Later changes to these inputs do not affect the running op.
//  PREP: signed ops (op[0]=1) take absolute values of both operands internally.
//   Record sign_q = sa^sb and sign_r = sa. Unsigned ops: both signs are 0.
//   Clear the accumulator; iteration counter = WIDTH-1.
//  ITER, multiply (shift-add):
//   alu_a = acc_hi. alu_b = mcand if mplier LSB=1, else 0. alucont = add.
//   Carry-out is derived from the operand MSBs and alu_result[WIDTH-1].
//   {carry, alu_result, mplier} shifts right 1 each cycle.
//  ITER, divide (restoring): alu_a = remainder shifted left 1 with the next dividend
//   bit in. alu_b = divisor. alucont = subtract.
//   No borrow (the 33-bit compare uses the shifted-out MSB): keep the difference, quotient bit 1.
//   Otherwise keep the shifted remainder, quotient bit 0.
//  alu_sel=1 only in ITER; alu_sel=0 in all other states.
//  FIXUP, multiply: {hi,lo} = sign_q ? -product(64b) : product.
//  FIXUP, divide: lo = sign_q ? -quot : quot; hi = sign_r ? -rem : rem.
//  Divide by zero: same latency. lo = all-ones, hi = original srca; no exception.
//  DIV 0x80000000 / -1: lo = 0x80000000, hi = 0 (two's-complement wrap, no trap).
//  MTHI/MTLO: honoured only in IDLE, same-cycle write. Ignored while busy.
//   If hi_we or lo_we coincides with an accepted start, the write lands first;
//   the op result later overwrites HI/LO.
//  Reset mid-op: returns to IDLE next edge. hi=lo=0; no done pulse is emitted.
//  hi/lo hold their previous values until the FIXUP load. The pipeline must not read them while busy.
// TESTING
//  T1 MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
//     done exactly in cycle 35; busy=1 in cycles 1..35 only.
//  T2 MULT -3*5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
//     MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
//  T3 DIVU 100/7 -> lo=14, hi=2. DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//     DIV 7/-2 -> lo=0xFFFFFFFD, hi=1.
//  T4 DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
//     DIVU 5/0 -> lo=0xFFFFFFFF, hi=5, done in cycle 35.
//  T5 start pulsed again in cycle 10 with different operands -> ignored; T1 result unchanged.
//     MTLO 0x1234 while busy -> lo unaffected. MTLO in IDLE -> lo=0x1234 next cycle.
//  T6 reset asserted in cycle 20 of a DIV -> cycle 21: busy=0, hi=lo=0, alu_sel=0, no done.
//     A new MULTU 6*7 then gives lo=42, hi=0.

Source files
------------

// File: rtl/muldiv_if.sv
// Handshake and shared-ALU bus between the core and the HI/LO multiply/divide sequencer.
interface muldiv_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] srca;
   logic [WIDTH-1:0] srcb;
   logic             hi_we;
   logic             lo_we;
   logic [WIDTH-1:0] wd;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             alu_sel;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [3:0]       alucont;
   logic [WIDTH-1:0] alu_result;

   modport slave (
      input  start, op, srca, srcb, hi_we, lo_we, wd, alu_result,
      output busy, done, hi, lo, alu_sel, alu_a, alu_b, alucont
   );

   modport master (
      output start, op, srca, srcb, hi_we, lo_we, wd, alu_result,
      input  busy, done, hi, lo, alu_sel, alu_a, alu_b, alucont
   );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO; borrows the shared ALU adder
// for one add (shift-add multiply) or subtract (restoring divide) per cycle.
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO honoured
// PREP  | absolute values, record signs, clear accumulator
// ITER  | WIDTH iterations through the shared ALU
// FIXUP | sign correction, load HI/LO
// DONE  | one-cycle done pulse
module muldiv_seq #(
   parameter int WIDTH = 32
) (
   input  logic      clk,
   input  logic      reset,
   muldiv_if.slave   bus
);
   localparam int         CW      = $clog2(WIDTH);
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;

   typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIXUP, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [1:0]       op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] mq_q, mq_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             sgn_quo_q, sgn_quo_d;
   logic             sgn_rem_q, sgn_rem_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;

   logic             alu_sel;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [3:0]       alucont;
   logic             sa, sb, carry, borrow, keep;
   logic [WIDTH-1:0] shifted;
   logic [2*WIDTH-1:0] prod;

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      a_d       = a_q;
      b_d       = b_q;
      acc_d     = acc_q;
      mq_d      = mq_q;
      cnt_d     = cnt_q;
      sgn_quo_d = sgn_quo_q;
      sgn_rem_d = sgn_rem_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      alu_sel   = 1'b0;
      alu_a     = '0;
      alu_b     = '0;
      alucont   = ALU_ADD;
      sa        = 1'b0;
      sb        = 1'b0;
      carry     = 1'b0;
      borrow    = 1'b0;
      keep      = 1'b0;
      shifted   = '0;
      prod      = '0;
      case (state_q)
         S_IDLE: begin
            if (bus.hi_we) hi_d = bus.wd;
            if (bus.lo_we) lo_d = bus.wd;
            if (bus.start) begin
               op_d    = bus.op;
               a_d     = bus.srca;
               b_d     = bus.srcb;
               state_d = S_PREP;
            end
         end
         S_PREP: begin
            sa        = op_q[0] & a_q[WIDTH-1];
            sb        = op_q[0] & b_q[WIDTH-1];
            mq_d      = sa ? -a_q : a_q;
            b_d       = sb ? -b_q : b_q;
            sgn_quo_d = sa ^ sb;
            sgn_rem_d = sa;
            acc_d     = '0;
            cnt_d     = CW'(WIDTH - 1);
            state_d   = S_ITER;
         end
         S_ITER: begin
            alu_sel = 1'b1;
            if (op_q[1]) begin
               shifted = {acc_q[WIDTH-2:0], mq_q[WIDTH-1]};
               alu_a   = shifted;
               alu_b   = b_q;
               alucont = ALU_SUB;
               // MSB borrow recovered from operand and result MSBs; acc_q MSB is the 33rd bit
               borrow  = (~alu_a[WIDTH-1] & alu_b[WIDTH-1]) |
                         (~(alu_a[WIDTH-1] ^ alu_b[WIDTH-1]) & bus.alu_result[WIDTH-1]);
               keep    = acc_q[WIDTH-1] | ~borrow;
               acc_d   = keep ? bus.alu_result : shifted;
               mq_d    = {mq_q[WIDTH-2:0], keep};
            end else begin
               alu_a   = acc_q;
               alu_b   = mq_q[0] ? b_q : '0;
               carry   = (alu_a[WIDTH-1] & alu_b[WIDTH-1]) |
                         ((alu_a[WIDTH-1] | alu_b[WIDTH-1]) & ~bus.alu_result[WIDTH-1]);
               acc_d   = {carry, bus.alu_result[WIDTH-1:1]};
               mq_d    = {bus.alu_result[0], mq_q[WIDTH-1:1]};
            end
            if (cnt_q == '0) state_d = S_FIXUP;
            else             cnt_d   = cnt_q - 1'b1;
         end
         S_FIXUP: begin
            if (op_q[1]) begin
               if (b_q == '0) begin
                  lo_d = '1;
                  hi_d = a_q;
               end else begin
                  lo_d = sgn_quo_q ? -mq_q : mq_q;
                  hi_d = sgn_rem_q ? -acc_q : acc_q;
               end
            end else begin
               prod = {acc_q, mq_q};
               if (sgn_quo_q) prod = -prod;
               {hi_d, lo_d} = prod;
            end
            state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         op_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         acc_q     <= '0;
         mq_q      <= '0;
         cnt_q     <= '0;
         sgn_quo_q <= 1'b0;
         sgn_rem_q <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         a_q       <= a_d;
         b_q       <= b_d;
         acc_q     <= acc_d;
         mq_q      <= mq_d;
         cnt_q     <= cnt_d;
         sgn_quo_q <= sgn_quo_d;
         sgn_rem_q <= sgn_rem_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   assign bus.busy    = (state_q != S_IDLE);
   assign bus.done    = (state_q == S_DONE);
   assign bus.hi      = hi_q;
   assign bus.lo      = lo_q;
   assign bus.alu_sel = alu_sel;
   assign bus.alu_a   = alu_a;
   assign bus.alu_b   = alu_b;
   assign bus.alucont = alucont;
endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: arithmetic reference model plus cycle-phase timing model,
// compared every cycle, with literal expectations for the directed vectors.
module tb_muldiv_seq;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;
   bit   chk_en = 1'b0;

   muldiv_if #(.WIDTH(32)) bus ();
   muldiv_seq #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   // Shared ALU stand-in: combinational add/subtract
   assign bus.alu_result = (bus.alucont == 4'b0110) ? bus.alu_a - bus.alu_b
                                                    : bus.alu_a + bus.alu_b;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] model_result(input logic [1:0] op, input logic [31:0] a,
                                                input logic [31:0] b);
      longint pa, pb, q, r;
      logic [63:0] res;
      pa = longint'($signed(a));
      pb = longint'($signed(b));
      case (op)
         2'd0: res = 64'(a) * 64'(b);
         2'd1: res = 64'(pa * pb);
         default: begin
            if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
            else if (op == 2'd2) res = {a % b, a / b};
            else begin
               q = pa / pb;
               r = pa % pb;
               res = {r[31:0], q[31:0]};
            end
         end
      endcase
      return res;
   endfunction

   // Timing model: phase = cycles since the accepted start (0 = idle)
   int          m_phase = 0;
   logic [31:0] m_hi = '0, m_lo = '0;
   logic [63:0] m_res = '0;
   bit          m_isdiv = 1'b0;

   always @(posedge clk) begin
      if (reset) begin
         m_phase = 0;
         m_hi = '0;
         m_lo = '0;
      end else if (m_phase == 0) begin
         if (bus.hi_we) m_hi = bus.wd;
         if (bus.lo_we) m_lo = bus.wd;
         if (bus.start) begin
            m_res   = model_result(bus.op, bus.srca, bus.srcb);
            m_isdiv = bus.op[1];
            m_phase = 1;
         end
      end else if (m_phase == 35) begin
         m_phase = 0;
      end else begin
         m_phase++;
         if (m_phase == 35) {m_hi, m_lo} = m_res;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("busy", bus.busy, m_phase != 0);
         check("done", bus.done, m_phase == 35);
         check("alu_sel", bus.alu_sel, m_phase >= 2 && m_phase <= 33);
         check("hi", bus.hi, m_hi);
         check("lo", bus.lo, m_lo);
         if (m_phase >= 2 && m_phase <= 33)
            check("alucont", bus.alucont, m_isdiv ? 4'b0110 : 4'b0010);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo, input bit inject);
      int done_cyc;
      check($sformatf("model_%s", name), model_result(op, a, b), {exp_hi, exp_lo});
      bus.op = op;
      bus.srca = a;
      bus.srcb = b;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.hi_we = 1'b0;
      bus.lo_we = 1'b0;
      bus.op = 2'($urandom);
      bus.srca = $urandom;
      bus.srcb = $urandom;
      done_cyc = -1;
      for (int c = 1; c <= 40; c++) begin
         if (inject && c == 10) begin
            bus.start = 1'b1;
            bus.op = 2'd2;
            bus.srca = 32'd1000;
            bus.srcb = 32'd3;
            bus.lo_we = 1'b1;
            bus.wd = 32'h1234;
         end else begin
            bus.start = 1'b0;
            bus.lo_we = 1'b0;
         end
         @(negedge clk);
         if (bus.done && done_cyc < 0) done_cyc = c;
         tick();
      end
      check($sformatf("done_cycle_%s", name), 64'(done_cyc), 64'd35);
      check($sformatf("hi_%s", name), bus.hi, exp_hi);
      check($sformatf("lo_%s", name), bus.lo, exp_lo);
   endtask

   initial begin
      int  done_seen;
      bus.start = 1'b0;
      bus.op = '0;
      bus.srca = '0;
      bus.srcb = '0;
      bus.hi_we = 1'b0;
      bus.lo_we = 1'b0;
      bus.wd = '0;
      reset = 1'b1;
      tick();
      tick();
      @(negedge clk);
      check("rst_busy", bus.busy, 1'b0);
      check("rst_done", bus.done, 1'b0);
      check("rst_alu_sel", bus.alu_sel, 1'b0);
      check("rst_hi", bus.hi, 32'd0);
      check("rst_lo", bus.lo, 32'd0);
      check("rst_alu_a", bus.alu_a, 32'd0);
      check("rst_alu_b", bus.alu_b, 32'd0);
      check("rst_alucont", bus.alucont, 4'b0010);
      chk_en = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;

      run_op("multu_max", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b1);

      bus.lo_we = 1'b1;
      bus.wd = 32'h1234;
      tick();
      bus.lo_we = 1'b0;
      @(negedge clk);
      check("mtlo_idle", bus.lo, 32'h1234);
      tick();

      run_op("mult_neg", 2'd1, -32'sd3, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
      run_op("mult_min", 2'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0);
      run_op("mult_m1m1", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 1'b0);
      run_op("divu_100_7", 2'd2, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
      run_op("div_m7_2", 2'd3, -32'sd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
      run_op("div_7_m2", 2'd3, 32'd7, -32'sd2, 32'd1, 32'hFFFF_FFFD, 1'b0);
      run_op("div_ovf", 2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
      run_op("divu_by0", 2'd2, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b0);
      run_op("div_by0", 2'd3, -32'sd9, 32'd0, 32'hFFFF_FFF7, 32'hFFFF_FFFF, 1'b0);
      run_op("divu_big", 2'd2, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF, 1'b0);

      // MTHI coinciding with an accepted start: write lands, result overwrites later
      bus.hi_we = 1'b1;
      bus.wd = 32'hABCD;
      run_op("multu_3_4", 2'd0, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);

      run_op("div_pre_rst", 2'd3, -32'sd100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0);
      bus.op = 2'd3;
      bus.srca = -32'sd100;
      bus.srcb = 32'd3;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (19) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clk);
      check("midrst_busy", bus.busy, 1'b0);
      check("midrst_alu_sel", bus.alu_sel, 1'b0);
      check("midrst_hi", bus.hi, 32'd0);
      check("midrst_lo", bus.lo, 32'd0);
      done_seen = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (bus.done) done_seen++;
      end
      check("midrst_no_done", 64'(done_seen), 64'd0);
      tick();

      run_op("multu_6_7", 2'd0, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
